// File: rtl/mem_arbiter_pkg.sv
// Shared memory-system constants: RAM geometry defaults
// and the port-select encoding used by the arbiter.
package mem_arbiter_pkg;

    localparam int RAM_WIDTH_DEF     = 16;
    localparam int RAM_ADDR_BITS_DEF = 12;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port
// synchronous RAM; one access per cycle, read latency 1.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [RAM_ADDR_BITS-1:0] a_addr,
    input  logic [RAM_WIDTH-1:0]     a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [RAM_WIDTH-1:0]     a_rdata,

    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [RAM_ADDR_BITS-1:0] b_addr,
    input  logic [RAM_WIDTH-1:0]     b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [RAM_WIDTH-1:0]     b_rdata,

    output logic                     ram_en,
    output logic                     ram_wr_en,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_data_in,
    input  logic [RAM_WIDTH-1:0]     ram_data_out
);

    logic r_lg;
    logic r_rd_pend;
    logic r_owner;

    logic w_gnt_a;
    logic w_gnt_b;
    logic w_gnt;
    logic w_gnt_port;
    logic w_gnt_we;

    // Grant decision: single requester wins, ties go to the
    // port that did not win last; nothing granted in reset.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                w_gnt_a = (r_lg == PORT_B);
                w_gnt_b = (r_lg == PORT_A);
            end else begin
                w_gnt_a = a_req;
                w_gnt_b = b_req;
            end
        end
    end

    assign w_gnt      = w_gnt_a | w_gnt_b;
    assign w_gnt_port = w_gnt_b ? PORT_B : PORT_A;
    assign w_gnt_we   = w_gnt_b ? b_we : a_we;

    assign a_gnt = w_gnt_a;
    assign b_gnt = w_gnt_b;

    // RAM command mux; address and data are zeroed when idle.
    always_comb begin
        ram_en      = w_gnt;
        ram_wr_en   = w_gnt & w_gnt_we;
        ram_addr    = '0;
        ram_data_in = '0;
        if (w_gnt_a) begin
            ram_addr    = a_addr;
            ram_data_in = a_wdata;
        end else if (w_gnt_b) begin
            ram_addr    = b_addr;
            ram_data_in = b_wdata;
        end
    end

    // Last-grant register; held when nobody is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lg <= PORT_B;
        end else if (w_gnt) begin
            r_lg <= w_gnt_port;
        end
    end

    // Read tracking: remember which port owns the data the
    // RAM returns next cycle. Writes never set the pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_owner   <= PORT_A;
        end else begin
            r_rd_pend <= w_gnt & ~w_gnt_we;
            if (w_gnt && !w_gnt_we) begin
                r_owner <= w_gnt_port;
            end
        end
    end

    assign a_rvalid = r_rd_pend & (r_owner == PORT_A);
    assign b_rvalid = r_rd_pend & (r_owner == PORT_B);

    assign a_rdata = a_rvalid ? ram_data_out : '0;
    assign b_rdata = b_rvalid ? ram_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks of mem_arbiter against a
// behavioural block RAM and a shadow memory.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [11:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [11:0] b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic        ram_en, ram_wr_en;
    logic [11:0] ram_addr;
    logic [15:0] ram_data_in, ram_data_out;

    logic        pl_en;
    logic [11:0] pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem [0:4095];

    int total;
    int bad;

    mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_gnt        (a_gnt),
        .a_rvalid     (a_rvalid),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_gnt        (b_gnt),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .ram_en       (ram_en),
        .ram_wr_en    (ram_wr_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port RAM with registered read.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (ram_wr_en) begin
                mem[ram_addr] <= ram_data_in;
                ram_data_out  <= ram_data_in;
            end else begin
                ram_data_out  <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_ports();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [15:0] sh [0:7];
    logic        mlg;
    logic        e_a, e_b;
    logic        x_arv, x_brv;
    logic [15:0] x_ard, x_brd;
    logic [11:0] x_addr;
    int          wa, wb;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        idle_ports();

        // Preload RAM while the arbiter is held in reset.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 12'(i);
            pl_data = 16'hA000 + 16'(i);
            sh[i]   = 16'hA000 + 16'(i);
        end
        @(negedge clk);
        pl_addr = 12'h010;
        pl_data = 16'h1234;
        @(negedge clk);
        pl_en = 1'b0;

        // Requests during reset are ignored.
        a_req = 1'b1; b_req = 1'b1;
        #1;
        chk("rst_a_gnt", 32'(a_gnt), 32'(0));
        chk("rst_b_gnt", 32'(b_gnt), 32'(0));
        chk("rst_ram_en", 32'(ram_en), 32'(0));
        chk("rst_ram_wr", 32'(ram_wr_en), 32'(0));
        chk("rst_a_rv", 32'(a_rvalid), 32'(0));
        chk("rst_b_rv", 32'(b_rvalid), 32'(0));

        @(negedge clk);
        reset = 1'b0;
        idle_ports();

        // Single A read of preloaded word.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
        #1;
        chk("r1_a_gnt", 32'(a_gnt), 32'(1));
        chk("r1_b_gnt", 32'(b_gnt), 32'(0));
        chk("r1_en", 32'(ram_en), 32'(1));
        chk("r1_wr", 32'(ram_wr_en), 32'(0));
        chk("r1_addr", 32'(ram_addr), 32'h010);
        @(negedge clk);
        idle_ports();
        #1;
        chk("r1_a_rv", 32'(a_rvalid), 32'(1));
        chk("r1_a_rd", 32'(a_rdata), 32'h1234);
        chk("r1_b_rv", 32'(b_rvalid), 32'(0));
        chk("idle_en", 32'(ram_en), 32'(0));
        chk("idle_addr", 32'(ram_addr), 32'(0));
        @(negedge clk);
        #1;
        chk("r1_a_rv_off", 32'(a_rvalid), 32'(0));
        chk("r1_a_rd_off", 32'(a_rdata), 32'(0));

        // Held tie after reset alternates A,B,A,B.
        pulse_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h001;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002;
        #1;
        chk("t0_a_gnt", 32'(a_gnt), 32'(1));
        chk("t0_b_gnt", 32'(b_gnt), 32'(0));
        chk("t0_addr", 32'(ram_addr), 32'h001);
        @(negedge clk);
        #1;
        chk("t1_b_gnt", 32'(b_gnt), 32'(1));
        chk("t1_a_gnt", 32'(a_gnt), 32'(0));
        chk("t1_addr", 32'(ram_addr), 32'h002);
        chk("t1_a_rv", 32'(a_rvalid), 32'(1));
        chk("t1_a_rd", 32'(a_rdata), 32'hA001);
        @(negedge clk);
        #1;
        chk("t2_a_gnt", 32'(a_gnt), 32'(1));
        chk("t2_b_rv", 32'(b_rvalid), 32'(1));
        chk("t2_b_rd", 32'(b_rdata), 32'hA002);
        chk("t2_a_rv", 32'(a_rvalid), 32'(0));
        @(negedge clk);
        #1;
        chk("t3_b_gnt", 32'(b_gnt), 32'(1));
        chk("t3_a_rd", 32'(a_rdata), 32'hA001);
        @(negedge clk);
        idle_ports();
        #1;
        chk("t4_b_rv", 32'(b_rvalid), 32'(1));
        chk("t4_b_rd", 32'(b_rdata), 32'hA002);

        // Write then read same address on consecutive cycles.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1;
        a_addr = 12'h020; a_wdata = 16'hBEEF;
        #1;
        chk("w_a_gnt", 32'(a_gnt), 32'(1));
        chk("w_wr", 32'(ram_wr_en), 32'(1));
        chk("w_din", 32'(ram_data_in), 32'hBEEF);
        chk("w_addr", 32'(ram_addr), 32'h020);
        @(negedge clk);
        a_we = 1'b0; a_wdata = '0;
        #1;
        chk("raw_gnt", 32'(a_gnt), 32'(1));
        chk("raw_wr", 32'(ram_wr_en), 32'(0));
        chk("w_no_rv", 32'(a_rvalid), 32'(0));
        chk("w_no_rd", 32'(a_rdata), 32'(0));
        @(negedge clk);
        idle_ports();
        #1;
        chk("raw_rv", 32'(a_rvalid), 32'(1));
        chk("raw_rd", 32'(a_rdata), 32'hBEEF);

        // B read granted, reset hits before the capturing edge.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h003;
        #1;
        chk("rr_b_gnt", 32'(b_gnt), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("rr_b_gnt_rst", 32'(b_gnt), 32'(0));
        chk("rr_en_rst", 32'(ram_en), 32'(0));
        @(negedge clk);
        #1;
        chk("rr_b_rv_rst", 32'(b_rvalid), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        b_req = 1'b0;
        #1;
        chk("rr_b_rv_rel", 32'(b_rvalid), 32'(0));
        @(negedge clk);
        #1;
        chk("rr_b_rv_post", 32'(b_rvalid), 32'(0));
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h004;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h005;
        #1;
        chk("rr_tie_a", 32'(a_gnt), 32'(1));
        chk("rr_tie_b", 32'(b_gnt), 32'(0));
        @(negedge clk);
        a_req = 1'b0;
        #1;
        chk("rr_b_gnt2", 32'(b_gnt), 32'(1));
        chk("rr_a_rd", 32'(a_rdata), 32'hA004);
        @(negedge clk);
        idle_ports();
        #1;
        chk("rr_b_rd", 32'(b_rdata), 32'hA005);
        @(negedge clk);
        #1;
        chk("id_en", 32'(ram_en), 32'(0));
        chk("id_addr", 32'(ram_addr), 32'(0));
        chk("id_a_rd", 32'(a_rdata), 32'(0));
        chk("id_b_rd", 32'(b_rdata), 32'(0));

        // Random two-port traffic against shadow memory.
        mlg   = 1'b1;
        x_arv = 1'b0; x_brv = 1'b0;
        x_ard = '0;   x_brd = '0;
        wa = 0; wb = 0;
        e_a = 1'b0; e_b = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (e_a) a_req = 1'b0;
            if (e_b) b_req = 1'b0;
            if (!a_req && $urandom_range(1, 0) == 1) begin
                a_req   = 1'b1;
                a_we    = 1'($urandom_range(1, 0));
                a_addr  = 12'($urandom_range(7, 0));
                a_wdata = 16'($urandom);
            end
            if (!b_req && $urandom_range(1, 0) == 1) begin
                b_req   = 1'b1;
                b_we    = 1'($urandom_range(1, 0));
                b_addr  = 12'($urandom_range(7, 0));
                b_wdata = 16'($urandom);
            end
            #1;
            e_a = a_req && (!b_req || mlg == 1'b1);
            e_b = b_req && (!a_req || mlg == 1'b0);
            x_addr = e_a ? a_addr : (e_b ? b_addr : 12'h000);
            chk("rnd_a_gnt", 32'(a_gnt), 32'(e_a));
            chk("rnd_b_gnt", 32'(b_gnt), 32'(e_b));
            chk("rnd_addr", 32'(ram_addr), 32'(x_addr));
            chk("rnd_a_rv", 32'(a_rvalid), 32'(x_arv));
            chk("rnd_a_rd", 32'(a_rdata), 32'(x_ard));
            chk("rnd_b_rv", 32'(b_rvalid), 32'(x_brv));
            chk("rnd_b_rd", 32'(b_rdata), 32'(x_brd));
            wa = (a_req && !a_gnt) ? wa + 1 : 0;
            wb = (b_req && !b_gnt) ? wb + 1 : 0;
            chk("rnd_starve_a", 32'(wa <= 1), 32'(1));
            chk("rnd_starve_b", 32'(wb <= 1), 32'(1));
            x_arv = 1'b0; x_brv = 1'b0;
            x_ard = '0;   x_brd = '0;
            if (e_a) begin
                mlg = 1'b0;
                if (a_we) begin
                    sh[a_addr[2:0]] = a_wdata;
                end else begin
                    x_arv = 1'b1;
                    x_ard = sh[a_addr[2:0]];
                end
            end else if (e_b) begin
                mlg = 1'b1;
                if (b_we) begin
                    sh[b_addr[2:0]] = b_wdata;
                end else begin
                    x_brv = 1'b1;
                    x_brd = sh[b_addr[2:0]];
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
